// File: rtl/ws_log_pkg.sv
// Shared definitions for the jitter-log frame assembler: header length,
// FSM encoding and frame-geometry helpers.
`timescale 1ns/1ps
package ws_log_pkg;

  localparam int HDR_LEN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } state_t;

  // Ceiling log2, used when sizing counters and address fields.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Number of hit-flag bytes for nc channels.
  function automatic int frame_nf(input int nc);
    return (nc + 7) / 8;
  endfunction

  // Total payload length in bytes.
  function automatic int frame_p(input int nc, input int nw);
    return HDR_LEN + frame_nf(nc) + nc * (nw / 8);
  endfunction

endpackage

// File: rtl/ws_log_snap.sv
// Frame snapshot register bank and the zero-latency addr-to-byte mux that
// feeds udp_send.
`timescale 1ns/1ps
module ws_log_snap
  import ws_log_pkg::*;
#(
  parameter int Nc  = 16,
  parameter int Nw  = 16,
  parameter int Nsz = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [Nc*Nw-1:0]  jtr_in,
  input  logic [31:0]       pcnt_in,
  input  logic [Nc-1:0]     flags_in,
  input  logic [15:0]       seq_in,
  input  logic [15:0]       drop_in,
  input  logic [Nsz-1:0]    addr,
  output logic [7:0]        payload
);

  localparam int NF = frame_nf(Nc);
  localparam int P  = frame_p(Nc, Nw);
  localparam int FW = P * 8;

  logic [31:0]      s_pcnt;
  logic [15:0]      s_seq;
  logic [15:0]      s_drop;
  logic [Nc-1:0]    s_flags;
  logic [Nc*Nw-1:0] s_jtr;

  logic [NF*8-1:0]  flags_pad;
  logic [FW-1:0]    frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pcnt  <= '0;
      s_seq   <= '0;
      s_drop  <= '0;
      s_flags <= '0;
      s_jtr   <= '0;
    end else if (cap) begin
      s_pcnt  <= pcnt_in;
      s_seq   <= seq_in;
      s_drop  <= drop_in;
      s_flags <= flags_in;
      s_jtr   <= jtr_in;
    end
  end

  always_comb begin
    flags_pad = '0;
    flags_pad[Nc-1:0] = s_flags;
  end

  // Byte 0 sits at the LSB, so every field lands little-endian and channel k
  // jitter falls at byte HDR_LEN+NF+k*Nb without any reordering.
  assign frame = {s_jtr, flags_pad, s_drop, s_seq, s_pcnt};

  always_comb begin
    payload = 8'h00;
    for (int i = 0; i < P; i++) begin
      if (addr == Nsz'(i)) payload = frame[i*8 +: 8];
    end
  end

endmodule

// File: rtl/ws_log_frame.sv
// Frame assembler between the per-channel jitter evaluators and udp_send:
// event masking, decimation, snapshot capture, pending/drop accounting.
`timescale 1ns/1ps
module ws_log_frame
  import ws_log_pkg::*;
#(
  parameter int Nc  = 16,
  parameter int Nw  = 16,
  parameter int Nsz = 7,
  parameter int Nto = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [Nc*Nw-1:0]  jtr,
  input  logic [Nc-1:0]     rdy_c,
  input  logic [Nc-1:0]     ch_mask,
  input  logic [31:0]       pcnt,
  input  logic [7:0]        dec,
  input  logic [Nsz-1:0]    addr,
  output logic [7:0]        payload,
  output logic              start,
  input  logic              tx_busy,
  output logic [15:0]       seq,
  output logic [15:0]       drop_cnt,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: start is a one-cycle pulse; udp_send answers by raising
  // tx_busy (ARM->SEND) and lowering it when done (SEND->IDLE). A missing
  // answer within 2**Nto cycles abandons the frame and counts it as lost.

  state_t           state;
  logic [7:0]       dec_cnt;
  logic             pending;
  logic [Nc-1:0]    pend_flags;
  logic [Nto-1:0]   to_cnt;

  logic [Nc-1:0]    ev_flags;
  logic             ev;
  logic             req;
  logic             cap;
  logic [Nc-1:0]    cap_flags;
  logic [Nc*Nw-1:0] jtr_m;
  logic             pend_drop;
  logic             to_drop;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;

  assign ev_flags  = rdy_c & ch_mask;
  assign ev        = |ev_flags;
  // ">=" so that lowering dec below the running count fires on the next event.
  assign req       = ev && (dec_cnt >= dec);
  assign cap       = (state == IDLE) && (req || pending);
  assign cap_flags = (req ? ev_flags : '0) | (pending ? pend_flags : '0);

  assign pend_drop = (state != IDLE) && req && pending;
  assign to_drop   = (state == ARM) && !tx_busy && (to_cnt == '1);
  assign drop_sum  = {1'b0, drop_cnt} + {16'd0, pend_drop} + {16'd0, to_drop};
  assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  assign dbg_state = state;

  // Channel 0 is the master reference and disabled channels carry no data.
  always_comb begin
    jtr_m = jtr;
    jtr_m[0 +: Nw] = '0;
    for (int k = 1; k < Nc; k++) begin
      if (!ch_mask[k]) jtr_m[k*Nw +: Nw] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (ev) begin
      dec_cnt <= req ? 8'd0 : dec_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      start      <= 1'b0;
      busy       <= 1'b0;
      seq        <= '0;
      drop_cnt   <= '0;
      pending    <= 1'b0;
      pend_flags <= '0;
      to_cnt     <= '0;
    end else begin
      start    <= 1'b0;
      drop_cnt <= drop_next;

      if ((state != IDLE) && req) begin
        pending    <= 1'b1;
        pend_flags <= pend_flags | ev_flags;
      end

      case (state)
        IDLE: begin
          if (cap) begin
            state      <= ARM;
            start      <= 1'b1;
            busy       <= 1'b1;
            seq        <= seq + 16'd1;
            pending    <= 1'b0;
            pend_flags <= '0;
            to_cnt     <= '0;
          end
        end
        ARM: begin
          if (tx_busy) begin
            state <= SEND;
          end else if (to_drop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            to_cnt <= to_cnt + Nto'(1);
          end
        end
        SEND: begin
          if (!tx_busy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ws_log_snap #(
    .Nc  (Nc),
    .Nw  (Nw),
    .Nsz (Nsz)
  ) u_snap (
    .clk      (clk),
    .rst      (rst),
    .cap      (cap),
    .jtr_in   (jtr_m),
    .pcnt_in  (pcnt),
    .flags_in (cap_flags),
    .seq_in   (seq + 16'd1),
    .drop_in  (drop_cnt),
    .addr     (addr),
    .payload  (payload)
  );

endmodule
